tlm_get_fifo: RTL

TLM_GET_FIFO -- requirements
Module: tlm_get_fifo

---
 rtl/tlm_get_fifo.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tlm_get_fifo.sv
// tlm_get_fifo: single-clock FIFO with a TLM-style get side.
//
// Put side : put_valid/put_ready handshake. A put transfers on a rising
//            edge where put_valid && put_ready are both high. put_ready is
//            registered and reflects whether the FIFO will have room in the
//            coming cycle.
// Get side : two ways to pop.
//            - Blocking get: the consumer raises get_req and holds it. The
//              FIFO pops as soon as an item is available. get_done pulses
//              for one cycle after the pop edge, with the item on rd_data.
//            - Nonblocking get: try_get is a one-cycle pulse. One cycle later
//              exactly one of try_ok (item on rd_data) or try_fail pulses.
//            At most one pop happens per cycle. A blocking pop wins over a
//            try_get, and the losing try_get answers try_fail.
// There is no bypass path. An item written at edge N can be popped from
// edge N+1 onwards.
module tlm_get_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       put_valid,
  input  logic [DATA_WIDTH-1:0]      put_data,
  output logic                       put_ready,
  input  logic                       get_req,
  output logic                       get_done,
  input  logic                       try_get,
  output logic                       try_ok,
  output logic                       try_fail,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       can_get,
  output logic [$clog2(DEPTH+1)-1:0] used,
  output logic [1:0]                 dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Blocking-get FSM encoding. These values are also visible on dbg_state.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  put_ready_q, put_ready_d;
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  try_ok_q, try_ok_d;
  logic                  try_fail_q, try_fail_d;

  logic                  not_empty;
  logic                  full;
  logic                  blk_pop;
  logic                  try_pop;
  logic                  pop;
  logic                  push;

  // Decide which transfers happen at the next edge.
  // put_ready_q is already low when the FIFO is full. The !full term only
  // guarantees that a full FIFO can never be overwritten.
  always_comb begin
    not_empty = (count_q != '0);
    full      = (count_q == DEPTH_C);
    blk_pop   = not_empty &&
                (((state_q == ST_IDLE) && get_req) || (state_q == ST_WAIT));
    try_pop   = try_get && not_empty && !blk_pop;
    pop       = blk_pop || try_pop;
    push      = put_valid && put_ready_q && !full;
  end

  // Compute the next blocking-get state. get_req is ignored while in DONE,
  // so every get completes with exactly one get_done pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (get_req) begin
          state_d = blk_pop ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (blk_pop) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Compute the next occupancy, pointers, registered outputs and pop data.
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    try_ok_d   = try_pop;
    try_fail_d = try_get && !try_pop;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    put_ready_d = (count_d < DEPTH_C);
  end

  // Write into the storage array. The array is not reset, because only
  // entries that have been written are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= put_data;
    end
  end

  // Update control and output registers. Reset drops all items and any
  // pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      put_ready_q <= 1'b0;
      state_q     <= ST_IDLE;
      rd_data_q   <= '0;
      try_ok_q    <= 1'b0;
      try_fail_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      put_ready_q <= put_ready_d;
      state_q     <= state_d;
      rd_data_q   <= rd_data_d;
      try_ok_q    <= try_ok_d;
      try_fail_q  <= try_fail_d;
    end
  end

  assign put_ready = put_ready_q;
  assign get_done  = (state_q == ST_DONE);
  assign try_ok    = try_ok_q;
  assign try_fail  = try_fail_q;
  assign rd_data   = rd_data_q;
  assign can_get   = (count_q != '0);
  assign used      = count_q;
  assign dbg_state = state_q;

endmodule
